// File: rtl/dds_sweep_controller.sv
// Linear frequency sweep sequencer feeding the DDS tuning word.
// Config is captured at start; modes: single, sawtooth repeat, triangle repeat.
module dds_sweep_controller #(
    parameter int FREQ_W  = 28,
    parameter int DWELL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [FREQ_W-1:0] cfg_start_freq,
    input  logic [FREQ_W-1:0] cfg_stop_freq,
    input  logic [FREQ_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]        cfg_mode,
    output logic [FREQ_W-1:0] freq_word,
    output logic              freq_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UP     = 2'd1;
    localparam logic [1:0] S_DOWN   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [FREQ_W-1:0]  start_q, start_d;
    logic [FREQ_W-1:0]  stop_q, stop_d;
    logic [FREQ_W-1:0]  step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         mode_q, mode_d;

    logic [FREQ_W:0]    up_sum;
    logic [FREQ_W-1:0]  up_next;
    logic [FREQ_W-1:0]  diff;
    logic [FREQ_W-1:0]  down_next;

    // One extra bit on the sum so a full-scale stop word clamps instead of wrapping.
    assign up_sum    = {1'b0, freq_q} + {1'b0, step_q};
    assign up_next   = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[FREQ_W-1:0];
    assign diff      = freq_q - step_q;
    assign down_next = ((freq_q < step_q) || (diff <= start_q)) ? start_q : diff;

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;

        if (state_q == S_IDLE) begin
            if (start && !abort) begin
                start_d = cfg_start_freq;
                stop_d  = cfg_stop_freq;
                step_d  = cfg_step;
                dwell_d = cfg_dwell;
                mode_d  = cfg_mode;
                freq_d  = cfg_start_freq;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                cnt_d   = cfg_dwell;
                state_d = ((cfg_step == '0) || (cfg_start_freq >= cfg_stop_freq))
                          ? S_FINISH : S_UP;
            end
        end else if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_UP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (freq_q == stop_q) begin
                        case (mode_q)
                            2'b01: begin
                                freq_d  = start_q;
                                valid_d = 1'b1;
                                cnt_d   = dwell_q;
                            end
                            2'b10: begin
                                state_d = S_DOWN;
                                freq_d  = down_next;
                                valid_d = 1'b1;
                                cnt_d   = dwell_q;
                            end
                            default: begin
                                state_d = S_FINISH;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end
                        endcase
                    end else begin
                        freq_d  = up_next;
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
                    end
                end
                S_DOWN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        if (freq_q == start_q) state_d = S_UP;
                        freq_d  = (freq_q == start_q) ? up_next : down_next;
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
                    end
                end
                default: begin
                    // A degenerate start lands here with done still low: hold the
                    // start word one cycle, then pulse done before returning idle.
                    if (done_q) begin
                        state_d = S_IDLE;
                    end else begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            freq_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
        end
    end

    assign freq_word  = freq_q;
    assign freq_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed bench for dds_sweep_controller: per-cycle vector table plus
// a hand-written async-reset sequence.
module tb_dds_sweep_controller;

    localparam int FREQ_W  = 28;
    localparam int DWELL_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort;
    logic [FREQ_W-1:0] cfg_start_freq, cfg_stop_freq, cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]        cfg_mode;
    logic [FREQ_W-1:0] freq_word;
    logic              freq_valid, busy, done;

    int checks = 0;
    int errors = 0;

    dds_sweep_controller #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .freq_word(freq_word), .freq_valid(freq_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Each row: inputs held for one cycle, outputs expected after that edge.
    typedef struct {
        logic              st, ab;
        logic [FREQ_W-1:0] s, p, stp;
        logic [DWELL_W-1:0] dw;
        logic [1:0]        md;
        logic [FREQ_W-1:0] ew;
        logic              ev, eb, ed;
    } vec_t;

    vec_t vecs[$];
    logic [FREQ_W-1:0] c_s, c_p, c_stp;
    logic [DWELL_W-1:0] c_dw;
    logic [1:0]        c_md;

    task automatic cfg(input logic [FREQ_W-1:0] s, p, stp, input logic [DWELL_W-1:0] dw,
                       input logic [1:0] md);
        c_s = s; c_p = p; c_stp = stp; c_dw = dw; c_md = md;
    endtask

    task automatic row(input logic st, ab, input logic [FREQ_W-1:0] ew,
                       input logic ev, eb, ed);
        vec_t v;
        v.st = st; v.ab = ab; v.s = c_s; v.p = c_p; v.stp = c_stp; v.dw = c_dw;
        v.md = c_md; v.ew = ew; v.ev = ev; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [FREQ_W-1:0] ew,
                           input logic ev, eb, ed);
        chk({tag, " freq_word"},  32'(freq_word),  32'(ew));
        chk({tag, " freq_valid"}, 32'(freq_valid), 32'(ev));
        chk({tag, " busy"},       32'(busy),       32'(eb));
        chk({tag, " done"},       32'(done),       32'(ed));
    endtask

    // Single sweep 100..130 step 10 dwell 2; noisy variant rewrites cfg and
    // holds start during the sweep, which must not change anything.
    task automatic single_seq(input bit noisy);
        cfg(100, 130, 10, 2, 0);
        row(1, 0, 100, 1, 1, 0);
        if (noisy) cfg(500, 200, 50, 0, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) row(noisy, 0, 28'(100 + 10 * k), 1, 1, 0);
            row(noisy, 0, 28'(100 + 10 * k), 0, 1, 0);
            row(k == 3 ? 1'b0 : noisy, 0, 28'(100 + 10 * k), 0, 1, 0);
        end
        row(0, 0, 130, 0, 0, 1);
        row(0, 0, 130, 0, 0, 0);
    endtask

    logic [FREQ_W-1:0] tri_seq [10];
    logic [FREQ_W-1:0] saw_seq [3];

    initial begin
        rst_n = 1'b0; start = 0; abort = 0;
        cfg_start_freq = '0; cfg_stop_freq = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
        repeat (2) @(posedge clk);
        #1 chk_out("reset", 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        single_seq(0);
        single_seq(1);

        // Triangle with clamps at both ends, dwell 0
        tri_seq = '{0, 10, 20, 25, 15, 5, 0, 10, 20, 25};
        cfg(0, 25, 10, 0, 2);
        row(1, 0, tri_seq[0], 1, 1, 0);
        for (int k = 1; k < 10; k++) row(0, 0, tri_seq[k], 1, 1, 0);
        row(0, 1, 25, 0, 0, 0);
        row(0, 0, 25, 0, 0, 0);

        // Sawtooth at full scale must clamp to stop, not wrap
        saw_seq = '{28'h0FFFFFF0, 28'h0FFFFFF8, 28'h0FFFFFFF};
        cfg(28'h0FFFFFF0, 28'h0FFFFFFF, 8, 0, 1);
        row(1, 0, saw_seq[0], 1, 1, 0);
        for (int k = 1; k < 7; k++) row(0, 0, saw_seq[k % 3], 1, 1, 0);
        row(0, 1, saw_seq[0], 0, 0, 0);

        // Abort mid single sweep, then restart
        cfg(100, 130, 10, 2, 0);
        row(1, 0, 100, 1, 1, 0);
        row(0, 0, 100, 0, 1, 0);
        row(0, 0, 100, 0, 1, 0);
        row(0, 0, 110, 1, 1, 0);
        row(0, 0, 110, 0, 1, 0);
        row(0, 1, 110, 0, 0, 0);
        row(0, 0, 110, 0, 0, 0);
        row(0, 0, 110, 0, 0, 0);
        row(1, 0, 100, 1, 1, 0);
        row(0, 1, 100, 0, 0, 0);

        // Degenerate: step 0, then start >= stop
        cfg(100, 130, 0, 2, 0);
        row(1, 0, 100, 1, 1, 0);
        row(0, 0, 100, 0, 0, 1);
        row(0, 0, 100, 0, 0, 0);
        cfg(200, 130, 10, 0, 1);
        row(1, 0, 200, 1, 1, 0);
        row(0, 0, 200, 0, 0, 1);
        row(0, 0, 200, 0, 0, 0);
        // start with abort in idle: nothing happens
        row(1, 1, 200, 0, 0, 0);
        // Mode 11 behaves as single
        cfg(0, 20, 10, 0, 3);
        row(1, 0, 0, 1, 1, 0);
        row(0, 0, 10, 1, 1, 0);
        row(0, 0, 20, 1, 1, 0);
        row(0, 0, 20, 0, 0, 1);
        row(0, 0, 20, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].st; abort = vecs[i].ab;
            cfg_start_freq = vecs[i].s; cfg_stop_freq = vecs[i].p; cfg_step = vecs[i].stp;
            cfg_dwell = vecs[i].dw; cfg_mode = vecs[i].md;
            @(posedge clk);
            #1 chk_out($sformatf("row%0d", i), vecs[i].ew, vecs[i].ev, vecs[i].eb, vecs[i].ed);
        end

        // Async reset between edges mid-sweep
        @(negedge clk);
        abort = 0; start = 1;
        cfg_start_freq = 100; cfg_stop_freq = 130; cfg_step = 10; cfg_dwell = 2; cfg_mode = 0;
        @(negedge clk) start = 0;
        @(posedge clk);
        #1 chk("pre-reset busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_out("async reset", 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 chk_out($sformatf("post-reset idle%0d", k), 0, 0, 0, 0);
        end
        @(negedge clk) start = 1;
        @(posedge clk);
        #1 chk_out("restart", 100, 1, 1, 0);
        @(negedge clk) start = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
